// File: rtl/ahblite_gcd_pkg.sv
// Shared register offsets, control-bit positions and FSM state encoding
// for the AHB-Lite GCD peripheral.
package ahblite_gcd_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] REG_A      = 2'd0;
  localparam logic [1:0] REG_B      = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  // START is a write-side bit; BUSY/DONE are read-side bits of CTRL
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/ahblite_gcd_core.sv
// Subtractive GCD engine: one subtract-or-finish step per clock while in CALC,
// with a sticky done flag that clears on the next start.
module gcd_core
  import ahblite_gcd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  gcd_state_t        state_reg, state_next;
  logic [DATA_W-1:0] wa_reg, wa_next;
  logic [DATA_W-1:0] wb_reg, wb_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              done_reg, done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wa_reg     <= '0;
      wb_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wa_reg     <= wa_next;
      wb_reg     <= wb_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wa_next     = wa_reg;
    wb_next     = wb_reg;
    result_next = result_reg;
    done_next   = done_reg;
    case (state_reg)
      IDLE, DONE: begin
        // A start landing in the single DONE cycle is honoured rather than lost
        if (start) begin
          state_next = CALC;
          wa_next    = a;
          wb_next    = b;
          done_next  = 1'b0;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (wb_reg == '0 || wa_reg == wb_reg) begin
          result_next = wa_reg;
          done_next   = 1'b1;
          state_next  = DONE;
        end else if (wa_reg == '0) begin
          result_next = wb_reg;
          done_next   = 1'b1;
          state_next  = DONE;
        end else if (wa_reg > wb_reg) begin
          wa_next = wa_reg - wb_reg;
        end else begin
          wb_next = wb_reg - wa_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg == CALC);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: rtl/ahblite_gcd.sv
// AHB-Lite zero-wait slave wrapping the GCD core: operand registers A/B,
// CTRL (start / done+busy status) and read-only RESULT.
module ahblite_gcd
  import ahblite_gcd_pkg::*;
#(
  parameter int DATA_W = BUS_W
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        gcd_irq
);

  logic [1:0]        addr_q;
  logic              wr_q;
  logic              valid_q;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic              core_busy, core_done;
  logic [DATA_W-1:0] core_result;
  logic              addr_phase;
  logic              wr_en;
  logic              start;

  // Bus fields the slave deliberately does not decode
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0]};

  assign addr_phase = HSEL & HTRANS[1] & HREADY;
  assign wr_en      = valid_q & wr_q;
  assign start      = wr_en && (addr_q == REG_CTRL) && HWDATA[CTRL_START] && !core_busy;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= addr_phase;
      if (addr_phase) begin
        addr_q <= HADDR[3:2];
        wr_q   <= HWRITE;
      end
    end
  end

  // Operands are frozen while the core is computing
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (wr_en && !core_busy) begin
      if (addr_q == REG_A) a_reg <= HWDATA;
      if (addr_q == REG_B) b_reg <= HWDATA;
    end
  end

  gcd_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk    (HCLK),
    .rst    (HRESET),
    .start  (start),
    .a      (a_reg),
    .b      (b_reg),
    .busy   (core_busy),
    .done   (core_done),
    .result (core_result)
  );

  always_comb begin
    HRDATA = '0;
    if (valid_q && !wr_q) begin
      case (addr_q)
        REG_A:      HRDATA = a_reg;
        REG_B:      HRDATA = b_reg;
        REG_CTRL: begin
          HRDATA[CTRL_BUSY] = core_busy;
          HRDATA[CTRL_DONE] = core_done;
        end
        REG_RESULT: HRDATA = core_result;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign gcd_irq   = core_done;

endmodule

// File: tb/tb_ahblite_gcd.sv
// Directed self-checking bench for ahblite_gcd: register access, GCD results,
// CALC latency, busy write protection, pipelined transfers and async reset.
module tb_ahblite_gcd;

  localparam logic [3:0] OFF_A      = 4'h0;
  localparam logic [3:0] OFF_B      = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h4000_0000;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [3:0]  HPROT = 4'b0011;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        gcd_irq;

  int vectors = 0;
  int miscompares = 0;

  ahblite_gcd dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .gcd_irq   (gcd_irq)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus clock: drive a new address phase plus HWDATA for the previous
  // transfer, and return HRDATA of the previous transfer's data phase.
  task automatic bus_cycle(input logic go, input logic wr, input logic [3:0] off,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    HSEL   = go;
    HTRANS = go ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = 32'h4000_0000 | {28'd0, off};
    HWDATA = wdata;
    #1 rdata = HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] off, input logic [31:0] data);
    logic [31:0] d;
    bus_cycle(1'b1, 1'b1, off, 32'h0, d);
    bus_cycle(1'b0, 1'b0, 4'h0, data, d);
  endtask

  task automatic read_reg(input logic [3:0] off, output logic [31:0] data);
    logic [31:0] d;
    bus_cycle(1'b1, 1'b0, off, 32'h0, d);
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, data);
  endtask

  // Write CTRL=1 and leave a CTRL read outstanding in its data phase slot
  task automatic issue_start();
    logic [31:0] d;
    bus_cycle(1'b1, 1'b1, OFF_CTRL, 32'h0, d);
    bus_cycle(1'b1, 1'b0, OFF_CTRL, 32'h1, d);
  endtask

  // Back-to-back CTRL reads, one per cycle, counting cycles with busy=1
  task automatic poll_done(input int limit, output int busy_cnt,
                           output logic [31:0] first_val, output logic [31:0] last_val);
    logic [31:0] d;
    busy_cnt  = 0;
    first_val = 32'h0;
    last_val  = 32'h0;
    for (int i = 0; i < limit; i++) begin
      bus_cycle(1'b1, 1'b0, OFF_CTRL, 32'h0, d);
      if (i == 0) first_val = d;
      last_val = d;
      if (d[0]) busy_cnt++;
      else break;
    end
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [3:0]  offs [4];
    offs = '{OFF_A, OFF_B, OFF_CTRL, OFF_RESULT};
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    vectors++;
    if (HRDATA !== 32'h0 || gcd_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: HRDATA=%h irq=%b, required 0/0", HRDATA, gcd_irq);
    end
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg(offs[i], d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_read_%0h: got %h, required 00000000", offs[i], d);
      end
      vectors++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_const: HREADYOUT=%b HRESP=%b, required 1/0", HREADYOUT, HRESP);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_gcd();
    logic [31:0] d, f, l;
    int cnt;
    write_reg(OFF_A, 32'd48);
    write_reg(OFF_B, 32'd18);
    issue_start();
    poll_done(50, cnt, f, l);
    vectors++;
    if (cnt != 5) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, required 5", cnt);
    end
    vectors++;
    if (l !== 32'h2) begin
      miscompares++;
      $display("FAIL basic_ctrl_done: got %h, required 00000002", l);
    end
    vectors++;
    if (gcd_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_irq: got %b, required 1", gcd_irq);
    end
    read_reg(OFF_RESULT, d);
    vectors++;
    if (d !== 32'd6) begin
      miscompares++;
      $display("FAIL basic_result: got %0d, required 6", d);
    end
    read_reg(OFF_A, d);
    vectors++;
    if (d !== 32'd48) begin
      miscompares++;
      $display("FAIL basic_readback_a: got %0d, required 48", d);
    end
    read_reg(OFF_B, d);
    vectors++;
    if (d !== 32'd18) begin
      miscompares++;
      $display("FAIL basic_readback_b: got %0d, required 18", d);
    end
    $display("test_basic_gcd done: gcd(48,18)");
  endtask

  task automatic test_zero_operands();
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    logic [31:0] te [2];
    logic [31:0] d, f, l;
    int cnt;
    ta = '{32'd0, 32'd0};
    tb = '{32'd7, 32'd0};
    te = '{32'd7, 32'd0};
    for (int i = 0; i < 2; i++) begin
      write_reg(OFF_A, ta[i]);
      write_reg(OFF_B, tb[i]);
      issue_start();
      poll_done(50, cnt, f, l);
      vectors++;
      if (f !== 32'h1) begin
        miscompares++;
        $display("FAIL zero_first_ctrl_%0d: got %h, required 00000001", i, f);
      end
      vectors++;
      if (cnt != 1 || l !== 32'h2) begin
        miscompares++;
        $display("FAIL zero_calc_len_%0d: busy %0d ctrl %h, required 1 / 00000002", i, cnt, l);
      end
      read_reg(OFF_RESULT, d);
      vectors++;
      if (d !== te[i]) begin
        miscompares++;
        $display("FAIL zero_result_%0d: got %0d, required %0d", i, d, te[i]);
      end
      $display("test_zero_operands: gcd(%0d,%0d) checked", ta[i], tb[i]);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d;
    write_reg(OFF_A, 32'hFFFF_FFFF);
    write_reg(OFF_B, 32'd1);
    issue_start();
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, d);
    write_reg(OFF_A, 32'd5);
    read_reg(OFF_A, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL busy_write_a: got %h, required ffffffff", d);
    end
    write_reg(OFF_CTRL, 32'h1);
    read_reg(OFF_CTRL, d);
    vectors++;
    if (d !== 32'h1 || gcd_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_second_start: ctrl %h irq %b, required 00000001 / 0", d, gcd_irq);
    end
    // Full run would take ~2^32 cycles; abort it with a reset instead
    HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    $display("test_busy_ignore done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, f, l;
    int cnt;
    bus_cycle(1'b1, 1'b1, OFF_A, 32'h0, d);
    bus_cycle(1'b1, 1'b1, OFF_B, 32'd35, d);
    bus_cycle(1'b1, 1'b1, OFF_CTRL, 32'd21, d);
    bus_cycle(1'b1, 1'b0, OFF_CTRL, 32'h1, d);
    poll_done(50, cnt, f, l);
    vectors++;
    if (f !== 32'h1) begin
      miscompares++;
      $display("FAIL b2b_read_busy: got %h, required 00000001", f);
    end
    vectors++;
    if (cnt != 4 || l !== 32'h2) begin
      miscompares++;
      $display("FAIL b2b_calc_len: busy %0d ctrl %h, required 4 / 00000002", cnt, l);
    end
    read_reg(OFF_RESULT, d);
    vectors++;
    if (d !== 32'd7) begin
      miscompares++;
      $display("FAIL b2b_result: got %0d, required 7", d);
    end
    $display("test_back_to_back done: gcd(35,21)");
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] d, f, l;
    logic [3:0]  offs [4];
    int cnt;
    offs = '{OFF_A, OFF_B, OFF_CTRL, OFF_RESULT};
    write_reg(OFF_A, 32'd1000);
    write_reg(OFF_B, 32'd3);
    issue_start();
    poll_done(10, cnt, f, l);
    vectors++;
    if (cnt != 10) begin
      miscompares++;
      $display("FAIL midcalc_still_busy: busy %0d cycles, required 10", cnt);
    end
    #2 HRESET = 1'b1;
    #1;
    vectors++;
    if (gcd_irq !== 1'b0 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      miscompares++;
      $display("FAIL midcalc_async_reset: irq %b rdata %h ready %b resp %b, required 0/0/1/0",
               gcd_irq, HRDATA, HREADYOUT, HRESP);
    end
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg(offs[i], d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL midcalc_read_%0h: got %h, required 00000000", offs[i], d);
      end
    end
    write_reg(OFF_A, 32'd9);
    write_reg(OFF_B, 32'd9);
    issue_start();
    poll_done(50, cnt, f, l);
    vectors++;
    if (cnt != 1 || l !== 32'h2) begin
      miscompares++;
      $display("FAIL restart_calc_len: busy %0d ctrl %h, required 1 / 00000002", cnt, l);
    end
    read_reg(OFF_RESULT, d);
    vectors++;
    if (d !== 32'd9) begin
      miscompares++;
      $display("FAIL restart_result: got %0d, required 9", d);
    end
    $display("test_reset_mid_calc done");
  endtask

  initial begin
    test_reset();
    test_basic_gcd();
    test_zero_operands();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
